// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundles the per-master request side and the shared slave bus.
//   master modport: arbiter view (consumes m_req/m_we/m_addr/m_wdata, s_rdata/s_ack;
//                   drives m_ack/m_err/m_rdata, s_req/s_we/s_addr/s_wdata, grant, busy)
//   slave modport:  environment view (masters plus memory/MMIO slave), directions mirrored
interface mem_bus_arbiter_if #(
    parameter int NUM_M = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic [NUM_M-1:0]    m_req, m_we, m_ack, m_err;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*DW-1:0] m_wdata;
    logic [DW-1:0]       m_rdata, s_wdata, s_rdata;
    logic [AW-1:0]       s_addr;
    logic                s_req, s_we, s_ack, busy;
    logic [1:0]          grant;
    modport master (
        input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        output m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, grant, busy
    );
    modport slave (
        output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
        input  m_ack, m_err, m_rdata, s_req, s_we, s_addr, s_wdata, grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory/MMIO slave bus among NUM_M masters,
//   one outstanding transaction, registered outputs, watchdog abort after TIMEOUT cycles.
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   bus_io - master modport of mem_bus_arbiter_if (per-master req/ack side + slave bus)
module mem_bus_arbiter #(
    parameter int NUM_M   = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_bus_arbiter_if.master bus_io
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t           state_q;
    logic [1:0]       ptr_q, grant_q, idx_d;
    logic [CW-1:0]    cnt_q;
    logic             s_req_q, s_we_q, busy_q, expire_d;
    logic [AW-1:0]    s_addr_q;
    logic [DW-1:0]    s_wdata_q, m_rdata_q;
    logic [NUM_M-1:0] m_ack_q, m_err_q;
    // Scan from farthest to nearest so the first requester after ptr is the last one written.
    always_comb begin
        idx_d = ptr_q;
        for (int k = NUM_M; k >= 1; k--)
            if (bus_io.m_req[(int'(ptr_q) + k) % NUM_M]) idx_d = 2'((int'(ptr_q) + k) % NUM_M);
    end
    assign expire_d = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 2'(NUM_M - 1);
            grant_q   <= '0;
            cnt_q     <= '0;
            s_req_q   <= 1'b0;
            s_we_q    <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_rdata_q <= '0;
            m_ack_q   <= '0;
            m_err_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|bus_io.m_req) begin
                    state_q   <= BUSY;
                    s_req_q   <= 1'b1;
                    s_we_q    <= bus_io.m_we[idx_d];
                    s_addr_q  <= bus_io.m_addr[int'(idx_d) * AW +: AW];
                    s_wdata_q <= bus_io.m_wdata[int'(idx_d) * DW +: DW];
                    grant_q   <= idx_d;
                    ptr_q     <= idx_d;
                    cnt_q     <= '0;
                    busy_q    <= 1'b1;
                end
                // An ack arriving on the expiry cycle still counts as success.
                BUSY: if (bus_io.s_ack || expire_d) begin
                    state_q   <= DONE;
                    s_req_q   <= 1'b0;
                    m_rdata_q <= bus_io.s_ack ? bus_io.s_rdata : '0;
                    m_ack_q   <= NUM_M'(1) << grant_q;
                    m_err_q   <= bus_io.s_ack ? '0 : NUM_M'(1) << grant_q;
                end else cnt_q <= cnt_q + CW'(1);
                DONE: begin
                    state_q <= IDLE;
                    m_ack_q <= '0;
                    m_err_q <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus_io.s_req   = s_req_q;
    assign bus_io.s_we    = s_we_q;
    assign bus_io.s_addr  = s_addr_q;
    assign bus_io.s_wdata = s_wdata_q;
    assign bus_io.m_rdata = m_rdata_q;
    assign bus_io.m_ack   = m_ack_q;
    assign bus_io.m_err   = m_err_q;
    assign bus_io.grant   = grant_q;
    assign bus_io.busy    = busy_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed vector table, hand-written corner sequences and a randomized
//   phase checked against a transaction-level round-robin/latency model.
module tb_mem_bus_arbiter;
    localparam int NM = 3, AW = 32, DW = 32, TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    mem_bus_arbiter_if #(.NUM_M(NM), .AW(AW), .DW(DW)) bus ();
    mem_bus_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus_io(bus)
    );
    typedef struct {
        logic [NM-1:0] mask;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rd;
        bit            chg;
        bit            per;
        int            exp_g;
        int            exp_n;
        bit            exp_err;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t          tbl [16];
    int            n_cmp = 0, n_bad = 0;
    logic [NM-1:0] req_a = '0, we_a = '0;
    logic [AW-1:0] addr_a [NM];
    logic [DW-1:0] wdata_a [NM];
    int            last_ack [NM];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive();
        bus.m_req = req_a;
        bus.m_we  = we_a;
        for (int i = 0; i < NM; i++) begin
            bus.m_addr[i*AW +: AW]  = addr_a[i];
            bus.m_wdata[i*DW +: DW] = wdata_a[i];
        end
    endtask

    // Called at a falling edge in IDLE with requests already driven; returns at the
    // falling edge of the IDLE cycle that follows DONE.
    task automatic txn(input int w, input int lat, input logic [DW-1:0] rd, input bit chg,
                       input int exp_n, input bit exp_err, input logic [DW-1:0] exp_rd,
                       output int ack_cyc);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew;
        int            n;
        ea = addr_a[w]; ed = wdata_a[w]; ew = we_a[w]; n = 0;
        @(negedge clk);
        while (bus.s_req === 1'b1 && n <= TO + 2) begin
            n++;
            chk("s_addr", 64'(bus.s_addr), 64'(ea));
            chk("s_wdata", 64'(bus.s_wdata), 64'(ed));
            chk("s_we", 64'(bus.s_we), 64'(ew));
            chk("grant", 64'(bus.grant), 64'(w));
            chk("busy_in_busy", 64'(bus.busy), 64'd1);
            chk("ack_in_busy", 64'(bus.m_ack), 64'd0);
            bus.s_ack   = (n == lat + 1);
            bus.s_rdata = bus.s_ack ? rd : $urandom();
            if (chg && n == 1) begin
                wdata_a[w] = ~ed;
                drive();
            end
            @(negedge clk);
        end
        bus.s_ack = 1'b0;
        chk("s_req_cycles", 64'(n), 64'(exp_n));
        chk("m_ack", 64'(bus.m_ack), 64'(3'b001 << w));
        chk("m_err", 64'(bus.m_err), exp_err ? 64'(3'b001 << w) : 64'd0);
        chk("m_rdata", 64'(bus.m_rdata), 64'(exp_rd));
        chk("busy_in_done", 64'(bus.busy), 64'd1);
        ack_cyc = cyc;
        @(negedge clk);
        chk("ack_pulse_len", 64'({bus.m_ack, bus.m_err}), 64'd0);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_s_req", 64'(bus.s_req), 64'd0);
    endtask

    task automatic reset_mid(input int m);
        int ac;
        req_a = '0;
        req_a[m] = 1'b1;
        addr_a[m] = $urandom();
        drive();
        @(negedge clk);
        chk("rm_s_req", 64'(bus.s_req), 64'd1);
        chk("rm_grant", 64'(bus.grant), 64'(m));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_s_req_after", 64'(bus.s_req), 64'd0);
        chk("rm_ack_after", 64'({bus.m_ack, bus.m_err}), 64'd0);
        chk("rm_busy_after", 64'(bus.busy), 64'd0);
        chk("rm_grant_after", 64'(bus.grant), 64'd0);
        rst = 1'b0;
        req_a = 3'b101;
        drive();
        txn(0, 0, 32'h5A5A_0000 | 32'(m), 1'b0, 1, 1'b0, 32'h5A5A_0000 | 32'(m), ac);
        req_a = '0;
        drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ac, w, lat, last;
        logic [DW-1:0] rd;
        tbl[0]  = '{3'b001, 1'b0, 32'h1000_0000, 32'h0,  0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 1, 1'b0, 32'hDEAD_BEEF};
        tbl[1]  = '{3'b111, 1'b0, 32'h2000_0000, 32'h1,  0, 32'h1111_1111, 1'b0, 1'b0, 1, 1, 1'b0, 32'h1111_1111};
        tbl[2]  = '{3'b111, 1'b1, 32'h2000_0010, 32'h2,  0, 32'h2222_2222, 1'b0, 1'b0, 2, 1, 1'b0, 32'h2222_2222};
        tbl[3]  = '{3'b111, 1'b0, 32'h2000_0020, 32'h3,  0, 32'h3333_3333, 1'b0, 1'b0, 0, 1, 1'b0, 32'h3333_3333};
        tbl[4]  = '{3'b111, 1'b0, 32'h2000_0030, 32'h4,  0, 32'h4444_4444, 1'b0, 1'b1, 1, 1, 1'b0, 32'h4444_4444};
        tbl[5]  = '{3'b111, 1'b1, 32'h2000_0040, 32'h5,  0, 32'h5555_5555, 1'b0, 1'b1, 2, 1, 1'b0, 32'h5555_5555};
        tbl[6]  = '{3'b111, 1'b0, 32'h2000_0050, 32'h6,  0, 32'h6666_6666, 1'b0, 1'b1, 0, 1, 1'b0, 32'h6666_6666};
        tbl[7]  = '{3'b010, 1'b0, 32'h3000_0000, 32'h7, 99, 32'h7777_7777, 1'b0, 1'b0, 1, 4, 1'b1, 32'h0};
        tbl[8]  = '{3'b010, 1'b0, 32'h3000_0004, 32'h8,  1, 32'h1234_5678, 1'b0, 1'b0, 1, 2, 1'b0, 32'h1234_5678};
        tbl[9]  = '{3'b010, 1'b1, 32'hF020_0000, 32'hA5, 2, 32'h0BAD_F00D, 1'b1, 1'b0, 1, 3, 1'b0, 32'h0BAD_F00D};
        tbl[10] = '{3'b100, 1'b0, 32'h4000_0000, 32'h9,  3, 32'hCAFE_F00D, 1'b0, 1'b0, 2, 4, 1'b0, 32'hCAFE_F00D};
        tbl[11] = '{3'b101, 1'b0, 32'h5000_0000, 32'hA,  0, 32'h0000_0001, 1'b0, 1'b0, 0, 1, 1'b0, 32'h0000_0001};
        tbl[12] = '{3'b110, 1'b1, 32'h5000_0100, 32'hB,  0, 32'h0000_0002, 1'b0, 1'b0, 1, 1, 1'b0, 32'h0000_0002};
        tbl[13] = '{3'b101, 1'b0, 32'h5000_0200, 32'hC,  0, 32'h0000_0003, 1'b0, 1'b0, 2, 1, 1'b0, 32'h0000_0003};
        tbl[14] = '{3'b011, 1'b0, 32'h5000_0300, 32'hD,  1, 32'h0000_0004, 1'b0, 1'b0, 0, 2, 1'b0, 32'h0000_0004};
        tbl[15] = '{3'b110, 1'b0, 32'h5000_0400, 32'hE,  5, 32'h0000_0005, 1'b0, 1'b0, 1, 4, 1'b1, 32'h0};
        for (int i = 0; i < NM; i++) begin
            addr_a[i] = '0;
            wdata_a[i] = '0;
            last_ack[i] = 0;
        end
        drive();
        bus.s_ack = 1'b0;
        bus.s_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_req", 64'(bus.s_req), 64'd0);
        chk("rst_ack_err", 64'({bus.m_ack, bus.m_err}), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_slave_bus", 64'({bus.s_we, bus.s_addr}), 64'd0);
        chk("rst_wdata_rdata", {bus.s_wdata, bus.m_rdata}, 64'd0);
        rst = 1'b0;
        for (int e = 0; e < 16; e++) begin
            for (int i = 0; i < NM; i++) begin
                addr_a[i]  = tbl[e].addr ^ (i == tbl[e].exp_g ? 32'h0 : 32'h100 << i);
                we_a[i]    = tbl[e].we ^ (i != tbl[e].exp_g);
                wdata_a[i] = i == tbl[e].exp_g ? tbl[e].wdata : $urandom();
            end
            req_a = tbl[e].mask;
            drive();
            txn(tbl[e].exp_g, tbl[e].lat, tbl[e].rd, tbl[e].chg, tbl[e].exp_n, tbl[e].exp_err,
                tbl[e].exp_rd, ac);
            if (tbl[e].per) chk("rr_period", 64'(ac - last_ack[tbl[e].exp_g]), 64'd9);
            last_ack[tbl[e].exp_g] = ac;
        end
        req_a = '0;
        drive();
        bus.s_ack = 1'b1;
        bus.s_rdata = 32'hBAD0_0ACC;
        @(negedge clk);
        bus.s_ack = 1'b0;
        chk("idle_ack_no_m_ack", 64'({bus.m_ack, bus.m_err}), 64'd0);
        chk("idle_ack_no_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("idle_ack_still_idle", 64'({bus.s_req, bus.m_ack}), 64'd0);
        reset_mid(2);
        reset_mid(0);
        last = 0;
        for (int t = 0; t < 150; t++) begin
            for (int i = 0; i < NM; i++)
                if (!req_a[i] && $urandom_range(1) == 1) begin
                    req_a[i]   = 1'b1;
                    we_a[i]    = 1'($urandom());
                    addr_a[i]  = $urandom();
                    wdata_a[i] = $urandom();
                end
            if (req_a == '0) req_a[t % NM] = 1'b1;
            drive();
            w = -1;
            for (int k = 1; k <= NM; k++)
                if (w < 0 && req_a[(last + k) % NM]) w = (last + k) % NM;
            lat = $urandom_range(0, 5);
            rd = $urandom();
            txn(w, lat, rd, $urandom_range(1) == 1, lat >= TO ? TO : lat + 1, lat >= TO,
                lat >= TO ? 32'h0 : rd, ac);
            req_a[w] = 1'b0;
            last = w;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
